// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Purpose  : Round-robin write-port arbiter with bounded burst locking in
//            front of a sync FIFO. Optional macro FIFO_ARB_STATS_EN adds
//            per-producer saturating accepted-beat counters (gnt_cnt).
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    input  logic                      fifo_full,
    output logic                      fifo_wr_en,
    output logic [DATA_W-1:0]         fifo_data,
`ifdef FIFO_ARB_STATS_EN
    output logic [NUM_REQ*16-1:0]     gnt_cnt,
`endif
    output logic                      busy
);

    localparam int         c_ptr_w     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [3:0] c_max_burst = 4'(MAX_BURST);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t               r_state, w_next_state;
    logic [c_ptr_w-1:0]   r_rr_ptr, w_next_ptr;
    logic [c_ptr_w-1:0]   r_owner, w_next_owner;
    logic [3:0]           r_beat_cnt, w_next_cnt;
    logic [c_ptr_w-1:0]   w_pick;
    logic                 w_found;
    logic [NUM_REQ-1:0]   w_gnt;
    logic [DATA_W-1:0]    w_data;

    function automatic logic [c_ptr_w-1:0] f_next_ptr(input logic [c_ptr_w-1:0] p);
        if (int'(p) == NUM_REQ - 1) begin
            f_next_ptr = '0;
        end else begin
            f_next_ptr = p + 1'b1;
        end
    endfunction

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
                w_found = 1'b1;
                w_pick  = c_ptr_w'((int'(r_rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        w_gnt        = '0;
        w_next_state = r_state;
        w_next_ptr   = r_rr_ptr;
        w_next_owner = r_owner;
        w_next_cnt   = r_beat_cnt;
        case (r_state)
            IDLE: begin
                if (rst_n && w_found && !fifo_full) begin
                    w_gnt[w_pick] = 1'b1;
                    if (MAX_BURST > 1) begin
                        w_next_state = BURST;
                        w_next_owner = w_pick;
                        w_next_cnt   = 4'd1;
                    end else begin
                        w_next_ptr = f_next_ptr(w_pick);
                    end
                end
            end
            BURST: begin
                if (!req[r_owner]) begin
                    w_next_state = IDLE;
                    w_next_ptr   = f_next_ptr(r_owner);
                    w_next_cnt   = '0;
                end else if (!fifo_full) begin
                    w_gnt[r_owner] = 1'b1;
                    if (r_beat_cnt + 4'd1 == c_max_burst) begin
                        w_next_state = IDLE;
                        w_next_ptr   = f_next_ptr(r_owner);
                        w_next_cnt   = '0;
                    end else begin
                        w_next_cnt = r_beat_cnt + 4'd1;
                    end
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        w_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_rr_ptr   <= w_next_ptr;
            r_owner    <= w_next_owner;
            r_beat_cnt <= w_next_cnt;
        end
    end

    assign gnt        = w_gnt;
    assign fifo_wr_en = |w_gnt;
    assign fifo_data  = w_data;
    assign busy       = (r_state == BURST);

`ifdef FIFO_ARB_STATS_EN
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
            logic [15:0] r_cnt;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (w_gnt[gi] && (r_cnt != 16'hFFFF)) begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end
            assign gnt_cnt[gi*16 +: 16] = r_cnt;
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Purpose  : Self-checking bench for fifo_wr_arbiter against a per-cycle
//            behavioural model; MAX_BURST=4 and MAX_BURST=1 instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic            fifo_full;
    logic [N-1:0]    gnt, gnt1;
    logic            wr_en, wr_en1, busy, busy1;
    logic [DW-1:0]   data, data1;
`ifdef FIFO_ARB_STATS_EN
    logic [N*16-1:0] gnt_cnt, gnt_cnt1;
`endif

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt),
        .fifo_full(fifo_full), .fifo_wr_en(wr_en), .fifo_data(data),
`ifdef FIFO_ARB_STATS_EN
        .gnt_cnt(gnt_cnt),
`endif
        .busy(busy));

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt1),
        .fifo_full(fifo_full), .fifo_wr_en(wr_en1), .fifo_data(data1),
`ifdef FIFO_ARB_STATS_EN
        .gnt_cnt(gnt_cnt1),
`endif
        .busy(busy1));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who holds the lock, beats taken, who has top priority.
    int m_owner;
    int m_beats;
    int m_prio;
    logic [N-1:0]  exp_gnt;
    logic [DW-1:0] exp_data;
    logic [N-1:0]  obs_gnt, obs_gnt1;
    logic [DW-1:0] obs_data1;
    logic          obs_wr, obs_busy1;

    task automatic model_reset();
        m_owner = -1;
        m_beats = 0;
        m_prio  = 0;
    endtask

    task automatic model_eval();
        int p;
        exp_gnt  = '0;
        exp_data = '0;
        if (rst_n && !fifo_full) begin
            if (m_owner >= 0) begin
                if (req[m_owner]) exp_gnt[m_owner] = 1'b1;
            end else begin
                for (int k = 0; k < N; k++) begin
                    p = (m_prio + k) % N;
                    if (req[p] && exp_gnt == '0) exp_gnt[p] = 1'b1;
                end
            end
        end
        for (int i = 0; i < N; i++)
            if (exp_gnt[i]) exp_data = req_data[i*DW +: DW];
    endtask

    task automatic model_commit();
        int g;
        g = -1;
        for (int i = 0; i < N; i++) if (exp_gnt[i]) g = i;
        if (!rst_n) begin
            model_reset();
        end else if (m_owner >= 0) begin
            if (!req[m_owner]) begin
                m_prio  = (m_owner + 1) % N;
                m_owner = -1;
            end else if (g >= 0) begin
                m_beats++;
                if (m_beats == MB) begin
                    m_prio  = (m_owner + 1) % N;
                    m_owner = -1;
                end
            end
        end else if (g >= 0) begin
            m_owner = g;
            m_beats = 1;
        end
    endtask

    // One clock: sample at negedge against the model, then commit at posedge.
    task automatic step();
        @(negedge clk);
        model_eval();
        obs_gnt   = gnt;
        obs_wr    = wr_en;
        obs_gnt1  = gnt1;
        obs_data1 = data1;
        obs_busy1 = busy1;
        n_checks++;
        if (gnt !== exp_gnt || wr_en !== (|exp_gnt) || data !== exp_data ||
            busy !== (m_owner >= 0)) begin
            n_fail++;
            $display("FAIL model_cycle t=%0t: gnt=%b wr=%b data=%h busy=%b, required gnt=%b wr=%b data=%h busy=%b",
                     $time, gnt, wr_en, data, busy, exp_gnt, |exp_gnt, exp_data, m_owner >= 0);
        end
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        req      = 4'b1111;
        req_data = 32'hDDCCBBAA;
        model_reset();
        #3;
        n_checks++;
        if (gnt !== 4'b0 || wr_en !== 1'b0 || data !== 8'h0 || busy !== 1'b0 ||
            gnt1 !== 4'b0 || busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: gnt=%b wr=%b data=%h busy=%b gnt1=%b busy1=%b, required all 0",
                     gnt, wr_en, data, busy, gnt1, busy1);
        end
        step();
        do_reset();
    endtask

    task automatic test_round_robin_burst();
        int writes;
        logic [N-1:0] want;
        do_reset();
        req      = 4'b1111;
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        writes   = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (c < 16 && obs_wr) writes++;
            want = 4'b0001 << ((c / 4) % 4);
            n_checks++;
            if (obs_gnt !== want) begin
                n_fail++;
                $display("FAIL rr_burst_order cycle %0d: gnt=%b, required %b", c, obs_gnt, want);
            end
        end
        n_checks++;
        if (writes != 16) begin
            n_fail++;
            $display("FAIL rr_burst_writes: %0d writes, required 16", writes);
        end
    endtask

    task automatic test_early_drop();
        int writes;
        do_reset();
        req      = 4'b0100;
        req_data = {8'h00, 8'h21, 8'h00, 8'h00};
        writes   = 0;
        for (int c = 0; c < 2; c++) begin
            step();
            if (obs_wr) writes++;
            req_data[2*DW +: DW] = 8'h22;
        end
        req = 4'b0000;
        step();
        if (obs_wr) writes++;
        n_checks++;
        if (writes != 2 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL early_drop: writes=%0d busy=%b, required writes=2 busy=0", writes, busy);
        end
        req      = 4'b1111;
        req_data = {8'h33, 8'h32, 8'h31, 8'h30};
        step();
        n_checks++;
        if (obs_gnt !== 4'b1000) begin
            n_fail++;
            $display("FAIL early_drop_next: gnt=%b, required 1000", obs_gnt);
        end
    endtask

    task automatic test_full_stall();
        logic [N-1:0] seq [8];
        seq = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0010};
        do_reset();
        req      = 4'b0011;
        req_data = {8'h00, 8'h00, 8'h51, 8'h50};
        for (int c = 0; c < 8; c++) begin
            fifo_full = (c >= 2 && c <= 4);
            step();
            n_checks++;
            if (obs_gnt !== seq[c] || obs_wr !== (|seq[c])) begin
                n_fail++;
                $display("FAIL full_stall cycle %0d: gnt=%b wr=%b, required gnt=%b", c, obs_gnt, obs_wr, seq[c]);
            end
        end
        fifo_full = 1'b0;
    endtask

    task automatic test_single_beat_rr();
        logic [N-1:0] want;
        do_reset();
        req      = 4'b0101;
        req_data = {8'h00, 8'h72, 8'h00, 8'h70};
        for (int c = 0; c < 8; c++) begin
            step();
            want = (c % 2 == 0) ? 4'b0001 : 4'b0100;
            n_checks++;
            if (obs_gnt1 !== want || obs_busy1 !== 1'b0 ||
                obs_data1 !== ((c % 2 == 0) ? 8'h70 : 8'h72)) begin
                n_fail++;
                $display("FAIL single_beat_rr cycle %0d: gnt=%b busy=%b data=%h, required gnt=%b busy=0",
                         c, obs_gnt1, obs_busy1, obs_data1, want);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req      = 4'b1111;
        req_data = {8'h93, 8'h92, 8'h91, 8'h90};
        repeat (6) step();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_busy: busy=%b, required 1", busy);
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (gnt !== 4'b0 || wr_en !== 1'b0 || data !== 8'h0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_burst: gnt=%b wr=%b data=%h busy=%b, required all 0",
                     gnt, wr_en, data, busy);
        end
        step();
        rst_n = 1'b1;
        step();
        n_checks++;
        if (obs_gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_first_grant: gnt=%b, required 0001", obs_gnt);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (req[i] && obs_gnt[i]) begin
                    if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                    else req_data[i*DW +: DW] = 8'($urandom_range(0, 255));
                end else if (!req[i] && $urandom_range(0, 2) == 0) begin
                    req[i] = 1'b1;
                    req_data[i*DW +: DW] = 8'($urandom_range(0, 255));
                end
            end
            fifo_full = ($urandom_range(0, 3) == 0);
        end
        fifo_full = 1'b0;
    endtask

`ifdef FIFO_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        req      = 4'b0010;
        req_data = {8'h00, 8'h00, 8'hB1, 8'h00};
        repeat (100) step();
        n_checks++;
        if (gnt_cnt[16 +: 16] !== 16'd100 || gnt_cnt1[16 +: 16] !== 16'd100) begin
            n_fail++;
            $display("FAIL stats_100: cnt=%0d cnt1=%0d, required 100", gnt_cnt[16 +: 16], gnt_cnt1[16 +: 16]);
        end
        repeat (69900) step();
        n_checks++;
        if (gnt_cnt !== {16'h0, 16'h0, 16'hFFFF, 16'h0} ||
            gnt_cnt1 !== {16'h0, 16'h0, 16'hFFFF, 16'h0}) begin
            n_fail++;
            $display("FAIL stats_saturate: gnt_cnt=%h gnt_cnt1=%h, required 00000000ffff0000",
                     gnt_cnt, gnt_cnt1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin_burst();
        test_early_drop();
        test_full_stall();
        test_single_beat_rr();
        test_reset_mid_burst();
        test_random();
`ifdef FIFO_ARB_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
